// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - two-port round-robin arbiter sequencing push/pop transactions onto an 8-deep LIFO
// Occupancy is tracked locally so that illegal operations never reach the stack.
module stack_arbiter #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_op,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_op,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_din,
  input  logic [DATA_W-1:0] stk_dout,
  input  logic              stk_empty,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              busy,
  output logic              sync_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t             state, state_nxt;
  logic               gnt_b;
  logic               last_b;
  logic               sel_b;
  logic               op_q;
  logic               err_q;
  logic               reject;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [CNT_W-1:0]   cnt_q;

  // B wins when it is alone, or when both request and A was granted last.
  assign sel_b  = b_req && (!a_req || !last_b);
  assign reject = op_q ? (cnt_q == '0) : (cnt_q == DEPTH_C);

  always_comb begin
    state_nxt = state;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    a_ack     = 1'b0;
    b_ack     = 1'b0;
    case (state)
      IDLE: begin
        if (a_req || b_req) state_nxt = ISSUE;
      end
      ISSUE: begin
        stk_push = !op_q && !reject;
        stk_pop  = op_q && !reject;
        state_nxt = (op_q && !reject) ? CAPTURE : RESP;
      end
      CAPTURE: begin
        state_nxt = RESP;
      end
      RESP: begin
        a_ack     = !gnt_b;
        b_ack     = gnt_b;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt_b    <= 1'b0;
      last_b   <= 1'b1;
      op_q     <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      sync_err <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (stk_empty != (cnt_q == '0)) sync_err <= 1'b1;
          if (a_req || b_req) begin
            gnt_b   <= sel_b;
            op_q    <= sel_b ? b_op : a_op;
            wdata_q <= sel_b ? b_wdata : a_wdata;
            err_q   <= 1'b0;
          end
        end
        ISSUE: begin
          err_q <= reject;
          if (!reject) begin
            if (op_q) cnt_q <= cnt_q - CNT_W'(1);
            else      cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        CAPTURE: rdata_q <= stk_dout;
        RESP:    last_b  <= gnt_b;
        default: ;
      endcase
    end
  end

  assign a_err   = a_ack && err_q;
  assign b_err   = b_ack && err_q;
  assign a_rdata = rdata_q;
  assign b_rdata = rdata_q;
  assign stk_din = wdata_q;
  assign count   = cnt_q;
  assign full    = (cnt_q == DEPTH_C);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_stack_arbiter.sv
// tb/tb_stack_arbiter.sv - scoreboard bench for stack_arbiter with a behavioural LIFO model
// Stimulus queues expected responses; a negedge monitor checks each ack against them.
module tb_stack_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_req = 1'b0, a_op = 1'b0, b_req = 1'b0, b_op = 1'b0;
  logic [7:0] a_wdata = '0, b_wdata = '0;
  logic       a_ack, a_err, b_ack, b_err;
  logic [7:0] a_rdata, b_rdata;
  logic       stk_push, stk_pop, stk_empty, full, busy, sync_err;
  logic [7:0] stk_din;
  logic [7:0] stk_dout = '0;
  logic [3:0] count;

  stack_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_op(a_op), .a_wdata(a_wdata), .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_op(b_op), .b_wdata(b_wdata), .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din), .stk_dout(stk_dout),
    .stk_empty(stk_empty), .count(count), .full(full), .busy(busy), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Behavioural 8-deep LIFO sharing the reset.
  logic [7:0] mem [8];
  int         sp = 0;
  logic       force_ne = 1'b0;
  int         cyc = 0;
  int         push_cnt = 0, pop_cnt = 0;

  assign stk_empty = force_ne ? 1'b0 : (sp == 0);

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (stk_push) push_cnt = push_cnt + 1;
    if (stk_pop)  pop_cnt  = pop_cnt + 1;
    if (reset) begin
      sp       <= 0;
      stk_dout <= '0;
    end else begin
      if (stk_push && sp < 8) begin
        mem[sp] <= stk_din;
        sp      <= sp + 1;
      end
      if (stk_pop && sp > 0) begin
        stk_dout <= mem[sp-1];
        sp       <= sp - 1;
      end
    end
  end

  typedef struct {
    bit       port;
    bit       is_pop;
    bit       err;
    bit [7:0] rdata;
    int       ack_cyc;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  always @(negedge clk) begin
    if (stk_push || stk_pop) check("strobe_excl", {31'd0, stk_push & stk_pop}, 32'd0);
    if (!reset && (a_ack || b_ack)) begin
      check("ack_onehot", {31'd0, a_ack & b_ack}, 32'd0);
      if (q.size() == 0) begin
        check("unexpected_ack", {31'd0, b_ack}, 32'd2);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("ack_port", {31'd0, b_ack}, {31'd0, e.port});
        check("ack_err", {31'd0, e.port ? b_err : a_err}, {31'd0, e.err});
        if (e.is_pop && !e.err)
          check("rdata", {24'd0, e.port ? b_rdata : a_rdata}, {24'd0, e.rdata});
        if (e.ack_cyc >= 0) check("ack_latency", cyc, e.ack_cyc);
      end
    end
  end

  task automatic expect_resp(input bit port, input bit op, input bit err,
                             input bit [7:0] rd, input int ack_cyc);
    exp_t e;
    e.port = port; e.is_pop = op; e.err = err; e.rdata = rd; e.ack_cyc = ack_cyc;
    q.push_back(e);
  endtask

  task automatic wait_ack(input bit port);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (port ? b_ack : a_ack) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("ack_timeout", 32'd0, 32'd1);
  endtask

  // One transaction from a single requester; latency assumes the FSM is idle when req rises.
  task automatic txn(input bit port, input bit op, input bit [7:0] data,
                     input bit err, input bit [7:0] rd);
    @(negedge clk);
    expect_resp(port, op, err, rd, cyc + ((op && !err) ? 3 : 2));
    if (port) begin b_req = 1'b1; b_op = op; b_wdata = data; end
    else      begin a_req = 1'b1; a_op = op; a_wdata = data; end
    wait_ack(port);
    if (port) b_req = 1'b0;
    else      a_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; a_req = 1'b0; b_req = 1'b0; force_ne = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int pc;
    // reset state
    do_reset();
    check("rst_ack", {30'd0, a_ack, b_ack}, 32'd0);
    check("rst_err", {30'd0, a_err, b_err}, 32'd0);
    check("rst_rdata", {24'd0, a_rdata}, 32'd0);
    check("rst_strobes", {30'd0, stk_push, stk_pop}, 32'd0);
    check("rst_din", {24'd0, stk_din}, 32'd0);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_flags", {29'd0, full, busy, sync_err}, 32'd0);

    // push, push, pop with count tracking
    txn(0, 0, 8'h11, 0, 8'h00); check("t1_count1", {28'd0, count}, 32'd1);
    txn(0, 0, 8'h22, 0, 8'h00); check("t1_count2", {28'd0, count}, 32'd2);
    txn(0, 1, 8'h00, 0, 8'h22); check("t1_count3", {28'd0, count}, 32'd1);

    // simultaneous requests alternate A,B,A,B
    do_reset();
    @(negedge clk);
    expect_resp(0, 0, 0, 8'h00, cyc + 2);
    expect_resp(1, 0, 0, 8'h00, cyc + 5);
    expect_resp(0, 0, 0, 8'h00, cyc + 8);
    expect_resp(1, 0, 0, 8'h00, cyc + 11);
    a_req = 1'b1; a_op = 1'b0; a_wdata = 8'hA1;
    b_req = 1'b1; b_op = 1'b0; b_wdata = 8'hB1;
    fork
      begin wait_ack(0); a_wdata = 8'hA2; wait_ack(0); a_req = 1'b0; end
      begin wait_ack(1); b_wdata = 8'hB2; wait_ack(1); b_req = 1'b0; end
    join
    check("t2_count", {28'd0, count}, 32'd4);
    txn(0, 1, 8'h00, 0, 8'hB2);
    txn(0, 1, 8'h00, 0, 8'hA2);
    txn(0, 1, 8'h00, 0, 8'hB1);
    txn(0, 1, 8'h00, 0, 8'hA1);

    // fill to full, overflow rejected, drain
    do_reset();
    for (int i = 1; i <= 8; i++) txn(i[0], 0, 8'(i), 0, 8'h00);
    check("t3_count", {28'd0, count}, 32'd8);
    check("t3_full", {31'd0, full}, 32'd1);
    pc = push_cnt;
    txn(0, 0, 8'h09, 1, 8'h00);
    check("t3_no_push", push_cnt - pc, 32'd0);
    check("t3_count_hold", {28'd0, count}, 32'd8);
    for (int i = 8; i >= 1; i--) txn(1, 1, 8'h00, 0, 8'(i));
    check("t3_drained", {27'd0, full, count}, 32'd0);

    // pop on empty rejected, rdata unchanged
    pc = pop_cnt;
    txn(0, 1, 8'h00, 1, 8'h00);
    check("t4_no_pop", pop_cnt - pc, 32'd0);
    check("t4_count", {28'd0, count}, 32'd0);
    check("t4_rdata", {16'd0, a_rdata, b_rdata}, 32'h0101);

    // reset while in CAPTURE aborts the pop
    do_reset();
    txn(0, 0, 8'h55, 0, 8'h00);
    @(negedge clk);
    a_req = 1'b1; a_op = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1; a_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("t5_count", {28'd0, count}, 32'd0);
    check("t5_busy0", {31'd0, busy}, 32'd0);
    txn(0, 0, 8'hAB, 0, 8'h00);
    check("t5_count1", {28'd0, count}, 32'd1);

    // sync_err is sticky until reset
    do_reset();
    @(negedge clk);
    check("t6_clean", {31'd0, sync_err}, 32'd0);
    force_ne = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_set", {31'd0, sync_err}, 32'd1);
    force_ne = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_sticky", {31'd0, sync_err}, 32'd1);
    do_reset();
    check("t6_cleared", {31'd0, sync_err}, 32'd0);

    repeat (4) @(negedge clk);
    check("sb_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
